// File: rtl/mac_sequencer.sv
// Dot-product issue controller: fetches signed pairs, drives the multiplier start/ready handshake, pulses acc_en.
// Done arrives 4 + N*(3+W) cycles after vec_start; stalls in FETCH on in_valid; watchdog under MAC_SEQ_TIMEOUT_EN.
module mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vec_start,
  input  logic [LEN_WIDTH-1:0]         vec_len,
  input  logic                         vec_abort,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  output logic                         mul_start,
  output logic signed [DATA_WIDTH-1:0] mul_m,
  output logic signed [DATA_WIDTH-1:0] mul_q,
  input  logic                         mul_ready,
  output logic                         clr_acc,
  output logic                         acc_en,
  input  logic [ACC_WIDTH-1:0]         acc_in,
  output logic [ACC_WIDTH-1:0]         result,
  output logic                         done,
  output logic                         busy,
  output logic [LEN_WIDTH-1:0]         count,
  output logic                         err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_ACCUM     = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  logic [2:0]           state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 fin_q;
  logic                 wd_fire;
  logic                 kill;

  assign kill      = (vec_abort && state != S_IDLE) || wd_fire;
  assign in_ready  = (state == S_FETCH) && !vec_abort;
  assign mul_start = (state == S_ISSUE);
  assign clr_acc   = (state == S_CLEAR);
  assign acc_en    = (state == S_ACCUM) && !vec_abort;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      count     <= '0;
      mul_m     <= '0;
      mul_q     <= '0;
      result    <= '0;
      fin_q     <= 1'b0;
      done      <= 1'b0;
    end else begin
      // done trails FINISH by one extra register stage so it lands with result already stable
      done  <= fin_q;
      fin_q <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (vec_start && !vec_abort) begin
            remaining <= vec_len;
            count     <= '0;
            state     <= S_CLEAR;
          end
          S_CLEAR: state <= (remaining == '0) ? S_FINISH : S_FETCH;
          S_FETCH: if (in_valid) begin
            mul_m <= in_a;
            mul_q <= in_b;
            state <= S_ISSUE;
          end
          S_ISSUE:     state <= S_WAIT_BUSY;
          S_WAIT_BUSY: if (!mul_ready) state <= S_WAIT_DONE;
          S_WAIT_DONE: if (mul_ready) state <= S_ACCUM;
          S_ACCUM: begin
            count     <= count + LEN_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            state     <= (remaining == LEN_WIDTH'(1)) ? S_FINISH : S_FETCH;
          end
          default: begin
            result <= acc_in;
            fin_q  <= 1'b1;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            waiting;

  assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
  assign wd_fire = waiting && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= wd_fire;
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if (waiting)
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  // TIMEOUT only sizes the watchdog; without it err is constant low
  assign wd_fire = 1'b0;
  assign err     = (TIMEOUT < 0);
`endif

endmodule
